hazard_ctl: RTL and testbench

Pipeline hazard and redirect controller for the five-stage core. It keeps a scoreboard of destination registers in flight between EX and WB and stalls or bubbles the instruction in ID on a read-after-write conflict. It also sequences the IF/ID and ID/EX squash after a taken branch or jump resolved in EX. Outputs drive the `stall` and `clr` inputs of the IF and ID stage registers; the block has no forwarding network.

---
 rtl/hazard_ctl_if.sv | 32 +++
 rtl/hazard_ctl.sv | 109 ++++++++++
 tb/tb_hazard_ctl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_if.sv
// ID-stage request and pipeline-control bundle between the core and hazard_ctl.
// The master side is the pipeline; the slave side is the hazard controller.
interface hazard_ctl_if #(
  parameter int REG_IDX_W = 5
);
  logic                 i_id_valid;
  logic                 i_id_rs1_en;
  logic                 i_id_rs2_en;
  logic [REG_IDX_W-1:0] i_id_rs1;
  logic [REG_IDX_W-1:0] i_id_rs2;
  logic                 i_id_dest_en;
  logic [REG_IDX_W-1:0] i_id_dest_reg;
  logic                 i_ex_hold;
  logic                 i_branch_taken;
  logic                 o_stall;
  logic                 o_flush_id;
  logic                 o_bubble_ex;
  logic                 o_redirect;
  logic [31:0]          o_hazard_cycles;

  modport master (
    output i_id_valid, i_id_rs1_en, i_id_rs2_en, i_id_rs1, i_id_rs2,
           i_id_dest_en, i_id_dest_reg, i_ex_hold, i_branch_taken,
    input  o_stall, o_flush_id, o_bubble_ex, o_redirect, o_hazard_cycles
  );

  modport slave (
    input  i_id_valid, i_id_rs1_en, i_id_rs2_en, i_id_rs1, i_id_rs2,
           i_id_dest_en, i_id_dest_reg, i_ex_hold, i_branch_taken,
    output o_stall, o_flush_id, o_bubble_ex, o_redirect, o_hazard_cycles
  );
endinterface

// File: rtl/hazard_ctl.sv
// RAW hazard scoreboard and taken-branch squash sequencer for the five-stage core.
//   state    | meaning
//   RUN      | normal issue; stalls on RAW hazards
//   REDIRECT | squashing IF/ID and ID/EX while IF refetches after a taken branch
module hazard_ctl #(
  parameter int REG_IDX_W    = 5,
  parameter int DEPTH        = 3,
  parameter int REDIRECT_LAT = 1
) (
  input  logic         clk,
  input  logic         clr,
  hazard_ctl_if.slave  bus
);
  localparam int LAT_M1 = (REDIRECT_LAT > 0) ? REDIRECT_LAT - 1 : 0;

  typedef enum logic {RUN, REDIRECT} state_t;
  typedef enum logic [2:0] {
    ACT_RESET, ACT_HOLD, ACT_BRANCH, ACT_SQUASH, ACT_HAZARD, ACT_ISSUE
  } act_t;

  state_t               state;
  logic [2:0]           cnt;
  logic [DEPTH-1:0]     sb_valid;
  logic [REG_IDX_W-1:0] sb_reg [DEPTH];
  logic [31:0]          hazard_cycles;

  logic rs1_hit;
  logic rs2_hit;
  logic hazard;
  act_t act;

  // WB slot is excluded: the register file writes before it is read.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (sb_valid[k] && (sb_reg[k] == bus.i_id_rs1)) rs1_hit = 1'b1;
      if (sb_valid[k] && (sb_reg[k] == bus.i_id_rs2)) rs2_hit = 1'b1;
    end
    hazard = bus.i_id_valid &&
             ((bus.i_id_rs1_en && (bus.i_id_rs1 != '0) && rs1_hit) ||
              (bus.i_id_rs2_en && (bus.i_id_rs2 != '0) && rs2_hit));
  end

  always_comb begin
    act = ACT_ISSUE;
    if (clr)                     act = ACT_RESET;
    else if (bus.i_ex_hold)      act = ACT_HOLD;
    else if (bus.i_branch_taken) act = ACT_BRANCH;
    else if (state == REDIRECT)  act = ACT_SQUASH;
    else if (hazard)             act = ACT_HAZARD;
  end

  always_comb begin
    bus.o_stall     = 1'b0;
    bus.o_flush_id  = 1'b0;
    bus.o_bubble_ex = 1'b0;
    case (act)
      ACT_RESET, ACT_BRANCH, ACT_SQUASH: begin
        bus.o_flush_id  = 1'b1;
        bus.o_bubble_ex = 1'b1;
      end
      ACT_HOLD:   bus.o_stall = 1'b1;
      ACT_HAZARD: begin
        bus.o_stall     = 1'b1;
        bus.o_bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (act == ACT_RESET) begin
      sb_valid      <= '0;
      state         <= RUN;
      cnt           <= '0;
      hazard_cycles <= '0;
      for (int k = 0; k < DEPTH; k++) sb_reg[k] <= '0;
    end else if (act != ACT_HOLD) begin
      for (int k = 1; k < DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_reg[k]   <= sb_reg[k-1];
      end
      sb_valid[0] <= (act == ACT_ISSUE) && bus.i_id_valid && bus.i_id_dest_en &&
                     (bus.i_id_dest_reg != '0);
      sb_reg[0]   <= bus.i_id_dest_reg;

      case (act)
        ACT_BRANCH: begin
          if (REDIRECT_LAT > 0) begin
            state <= REDIRECT;
            cnt   <= 3'(LAT_M1);
          end else begin
            state <= RUN;
          end
        end
        ACT_SQUASH: begin
          if (cnt == 3'd0) state <= RUN;
          else             cnt   <= cnt - 3'd1;
        end
        ACT_HAZARD: hazard_cycles <= hazard_cycles + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.o_redirect      = (state == REDIRECT);
  assign bus.o_hazard_cycles = hazard_cycles;
endmodule

// File: tb/tb_hazard_ctl.sv
// Randomized and directed bench for hazard_ctl against an in-flight-register queue model.
module tb_hazard_ctl;
  localparam int REG_IDX_W    = 5;
  localparam int DEPTH        = 3;
  localparam int REDIRECT_LAT = 1;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  hazard_ctl_if #(.REG_IDX_W(REG_IDX_W)) bus ();

  hazard_ctl #(
    .REG_IDX_W    (REG_IDX_W),
    .DEPTH        (DEPTH),
    .REDIRECT_LAT (REDIRECT_LAT)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // in-flight destinations, youngest first; -1 means empty slot
  int          m_sb[$];
  bit          m_redir;
  int          m_cnt;
  bit [31:0]   m_hc;

  logic obs_stall, obs_flush, obs_bubble, obs_redirect;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int r);
    for (int i = 0; i < DEPTH - 1; i++)
      if (m_sb[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_push(input int v);
    m_sb.push_front(v);
    void'(m_sb.pop_back());
  endfunction

  function automatic void m_reset();
    m_sb.delete();
    for (int i = 0; i < DEPTH; i++) m_sb.push_back(-1);
    m_redir = 1'b0;
    m_cnt   = 0;
    m_hc    = '0;
  endfunction

  task automatic set_id(input bit v, input bit r1e, input int r1, input bit r2e, input int r2,
                        input bit de, input int d);
    bus.i_id_valid    = v;
    bus.i_id_rs1_en   = r1e;
    bus.i_id_rs1      = REG_IDX_W'(r1);
    bus.i_id_rs2_en   = r2e;
    bus.i_id_rs2      = REG_IDX_W'(r2);
    bus.i_id_dest_en  = de;
    bus.i_id_dest_reg = REG_IDX_W'(d);
  endtask

  task automatic set_ctl(input bit c, input bit h, input bit b);
    clr                = c;
    bus.i_ex_hold      = h;
    bus.i_branch_taken = b;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit hz, es, ef, eb;
    bit c, h, b, v, de;
    int d;
    #1;
    c  = clr;
    h  = bus.i_ex_hold;
    b  = bus.i_branch_taken;
    v  = bus.i_id_valid;
    de = bus.i_id_dest_en;
    d  = int'(bus.i_id_dest_reg);
    hz = v && ((bus.i_id_rs1_en && bus.i_id_rs1 != 0 && m_hit(int'(bus.i_id_rs1))) ||
               (bus.i_id_rs2_en && bus.i_id_rs2 != 0 && m_hit(int'(bus.i_id_rs2))));
    if (c)            {es, ef, eb} = 3'b011;
    else if (h)       {es, ef, eb} = 3'b100;
    else if (b)       {es, ef, eb} = 3'b011;
    else if (m_redir) {es, ef, eb} = 3'b011;
    else if (hz)      {es, ef, eb} = 3'b101;
    else              {es, ef, eb} = 3'b000;
    check("stall",    32'(bus.o_stall),     32'(es));
    check("flush_id", 32'(bus.o_flush_id),  32'(ef));
    check("bubble",   32'(bus.o_bubble_ex), 32'(eb));
    check("redirect", 32'(bus.o_redirect),  32'(m_redir));
    check("hz_count", bus.o_hazard_cycles,  m_hc);
    obs_stall    = bus.o_stall;
    obs_flush    = bus.o_flush_id;
    obs_bubble   = bus.o_bubble_ex;
    obs_redirect = bus.o_redirect;
    @(posedge clk);
    if (c) begin
      m_reset();
    end else if (!h) begin
      if (b) begin
        m_push(-1);
        m_redir = (REDIRECT_LAT > 0);
        m_cnt   = (REDIRECT_LAT > 0) ? REDIRECT_LAT - 1 : 0;
      end else if (m_redir) begin
        m_push(-1);
        if (m_cnt == 0) m_redir = 1'b0;
        else            m_cnt--;
      end else if (hz) begin
        m_push(-1);
        m_hc++;
      end else begin
        m_push((v && de && d != 0) ? d : -1);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int stalls;
    bit [31:0] hc0;

    set_ctl(1, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_reset();

    // reset state
    tick();
    set_ctl(0, 0, 0);
    tick();
    check("rst_redirect", 32'(obs_redirect), 32'd0);
    check("rst_hz_count", bus.o_hazard_cycles, 32'd0);

    // back-to-back RAW: addi x1 then add x2,x1,x3
    set_id(1, 1, 0, 0, 0, 1, 1); tick();
    set_id(1, 1, 1, 1, 3, 1, 2);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_stall && obs_bubble) stalls++;
    end
    check("raw_stalls", 32'(stalls), 32'd2);
    check("raw_issue", 32'(obs_stall), 32'd0);
    check("raw_hz_count", bus.o_hazard_cycles, 32'd2);

    // x0 producer and reader
    set_id(1, 0, 0, 0, 0, 1, 0); tick();
    set_id(1, 1, 0, 1, 0, 0, 0); tick();
    check("x0_no_stall", 32'(obs_stall), 32'd0);
    // producer to x5 then non-reading rs1=5
    set_id(1, 0, 0, 0, 0, 1, 5); tick();
    set_id(1, 0, 5, 0, 5, 0, 0); tick();
    check("noread_no_stall", 32'(obs_stall), 32'd0);

    // EX hold in the middle of a stall
    set_id(1, 0, 0, 0, 0, 1, 4); tick();
    set_id(1, 1, 4, 0, 0, 0, 0); tick();
    check("hold_pre_stall", 32'(obs_stall), 32'd1);
    hc0 = bus.o_hazard_cycles;
    set_ctl(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stall", 32'(obs_stall), 32'd1);
      check("hold_bubble", 32'(obs_bubble), 32'd0);
      check("hold_hz_frozen", bus.o_hazard_cycles, hc0);
    end
    set_ctl(0, 0, 0);
    tick();
    check("hold_rem_stall", 32'(obs_stall), 32'd1);
    tick();
    check("hold_then_issue", 32'(obs_stall), 32'd0);

    // taken branch with REDIRECT_LAT=1
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 1); tick();
    check("br_flush", 32'(obs_flush & obs_bubble), 32'd1);
    check("br_redirect_off", 32'(obs_redirect), 32'd0);
    set_ctl(0, 0, 0); tick();
    check("redir_flush", 32'(obs_flush & obs_bubble), 32'd1);
    check("redir_on", 32'(obs_redirect), 32'd1);
    tick();
    check("redir_done", 32'(obs_redirect), 32'd0);
    check("redir_done_flush", 32'(obs_flush), 32'd0);

    // branch beats a pending hazard
    set_id(1, 0, 0, 0, 0, 1, 1); tick();
    set_id(1, 1, 1, 0, 0, 1, 2);
    set_ctl(0, 0, 1);
    hc0 = bus.o_hazard_cycles;
    tick();
    check("brhz_stall", 32'(obs_stall), 32'd0);
    check("brhz_flush", 32'(obs_flush), 32'd1);
    check("brhz_hz_count", bus.o_hazard_cycles, hc0);
    set_ctl(0, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // reset during REDIRECT with x7 in flight
    set_id(1, 0, 0, 0, 0, 1, 7); tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0, 1); tick();
    set_ctl(1, 0, 0); tick();
    check("midrst_redirect", 32'(bus.o_redirect), 32'd0);
    set_ctl(0, 0, 0);
    set_id(1, 1, 7, 0, 0, 0, 0); tick();
    check("midrst_x7_issue", 32'(obs_stall), 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      set_ctl($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8);
      set_id($urandom_range(0, 99) < 85,
             $urandom_range(0, 99) < 70, int'($urandom_range(0, 7)),
             $urandom_range(0, 99) < 70, int'($urandom_range(0, 7)),
             $urandom_range(0, 99) < 70, int'($urandom_range(0, 7)));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
